// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - main control state machine for the multicycle datapath
//
// Purpose:
//   Sequences each instruction through fetch, decode, execute, memory and
//   writeback, one state per cycle. Memory states stall on i_MemReady.
//   Outputs are Moore-decoded from the registered state, except IRWrite and
//   PCWrite in FETCH (wait for i_MemReady), IllegalOp in DECODE (depends on
//   i_Op) and InstrDone in MEMWR (waits for i_MemReady).
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Rst        synchronous reset, active-high; forces all outputs to 0
//   i_Op         opcode field of the instruction register
//   i_MemReady   memory completes the current read/write this cycle
//   o_AluSrcA    0=PC, 1=RegA
//   o_AluSrcB    00=RegB, 01=const 1, 10=Imm, 11=shifted Imm
//   o_AluOp      00=add, 01=sub, 10=use funct
//   o_IorD       memory address: 0=PC, 1=ALUOut
//   o_MemRead    memory read request
//   o_MemWrite   memory write request
//   o_IRWrite    load instruction register
//   o_RegDst     write register: 0=rt, 1=rd
//   o_MemtoReg   writeback data: 0=ALUOut, 1=MDR
//   o_RegWrite   register file write enable
//   o_PCWrite    unconditional PC load
//   o_Branch     conditional PC load
//   o_PCSrc      00=ALU result, 01=ALUOut, 10=jump target
//   o_IllegalOp  unrecognised opcode seen in DECODE
//   o_InstrDone  final cycle of an instruction
//   o_State      current state encoding

module multicycle_ctrl_fsm #(
  parameter int              OP_W     = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = 6'h00,
  parameter logic [OP_W-1:0] OP_LW    = 6'h23,
  parameter logic [OP_W-1:0] OP_SW    = 6'h2B,
  parameter logic [OP_W-1:0] OP_BEQ   = 6'h04,
  parameter logic [OP_W-1:0] OP_ADDI  = 6'h08,
  parameter logic [OP_W-1:0] OP_J     = 6'h02
) (
  input  logic            i_Clk,
  input  logic            i_Rst,
  input  logic [OP_W-1:0] i_Op,
  input  logic            i_MemReady,
  output logic            o_AluSrcA,
  output logic [1:0]      o_AluSrcB,
  output logic [1:0]      o_AluOp,
  output logic            o_IorD,
  output logic            o_MemRead,
  output logic            o_MemWrite,
  output logic            o_IRWrite,
  output logic            o_RegDst,
  output logic            o_MemtoReg,
  output logic            o_RegWrite,
  output logic            o_PCWrite,
  output logic            o_Branch,
  output logic [1:0]      o_PCSrc,
  output logic            o_IllegalOp,
  output logic            o_InstrDone,
  output logic [3:0]      o_State
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXECR  = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_EXECI  = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = i_MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (i_Op == OP_LW || i_Op == OP_SW) begin
          state_d = S_MEMADR;
        end else if (i_Op == OP_RTYPE) begin
          state_d = S_EXECR;
        end else if (i_Op == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (i_Op == OP_ADDI) begin
          state_d = S_EXECI;
        end else if (i_Op == OP_J) begin
          state_d = S_JUMP;
        end else begin
          state_d = S_FETCH;
        end
      end
      // IR is held through MEMADR, so i_Op still selects load vs store here.
      S_MEMADR: state_d = (i_Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = i_MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = i_MemReady ? S_FETCH : S_MEMWR;
      S_EXECR:  state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_EXECI:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  logic opcode_known;
  assign opcode_known = (i_Op == OP_RTYPE) || (i_Op == OP_LW)  || (i_Op == OP_SW) ||
                        (i_Op == OP_BEQ)   || (i_Op == OP_ADDI) || (i_Op == OP_J);

  // Output decode. Reset overrides everything in the same cycle, so a memory
  // request in flight is dropped immediately rather than at the next edge.
  always_comb begin
    o_AluSrcA   = 1'b0;
    o_AluSrcB   = 2'b00;
    o_AluOp     = 2'b00;
    o_IorD      = 1'b0;
    o_MemRead   = 1'b0;
    o_MemWrite  = 1'b0;
    o_IRWrite   = 1'b0;
    o_RegDst    = 1'b0;
    o_MemtoReg  = 1'b0;
    o_RegWrite  = 1'b0;
    o_PCWrite   = 1'b0;
    o_Branch    = 1'b0;
    o_PCSrc     = 2'b00;
    o_IllegalOp = 1'b0;
    o_InstrDone = 1'b0;
    o_State     = 4'd0;
    if (!i_Rst) begin
      o_State = state_q;
      case (state_q)
        S_FETCH: begin
          // PC + 1 computed every cycle; only committed when memory is ready.
          o_MemRead = 1'b1;
          o_AluSrcB = 2'b01;
          o_IRWrite = i_MemReady;
          o_PCWrite = i_MemReady;
        end
        S_DECODE: begin
          // Speculative branch target into ALUOut.
          o_AluSrcB   = 2'b11;
          o_IllegalOp = !opcode_known;
        end
        S_MEMADR: begin
          o_AluSrcA = 1'b1;
          o_AluSrcB = 2'b10;
        end
        S_MEMRD: begin
          o_MemRead = 1'b1;
          o_IorD    = 1'b1;
        end
        S_MEMWB: begin
          o_MemtoReg  = 1'b1;
          o_RegWrite  = 1'b1;
          o_InstrDone = 1'b1;
        end
        S_MEMWR: begin
          o_MemWrite  = 1'b1;
          o_IorD      = 1'b1;
          o_InstrDone = i_MemReady;
        end
        S_EXECR: begin
          o_AluSrcA = 1'b1;
          o_AluOp   = 2'b10;
        end
        S_ALUWB: begin
          o_RegDst    = 1'b1;
          o_RegWrite  = 1'b1;
          o_InstrDone = 1'b1;
        end
        S_BRANCH: begin
          o_AluSrcA   = 1'b1;
          o_AluOp     = 2'b01;
          o_Branch    = 1'b1;
          o_PCSrc     = 2'b01;
          o_InstrDone = 1'b1;
        end
        S_EXECI: begin
          o_AluSrcA = 1'b1;
          o_AluSrcB = 2'b10;
        end
        S_IWB: begin
          o_RegWrite  = 1'b1;
          o_InstrDone = 1'b1;
        end
        S_JUMP: begin
          o_PCWrite   = 1'b1;
          o_PCSrc     = 2'b10;
          o_InstrDone = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed scoreboard bench for multicycle_ctrl_fsm

module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic       rdy;
  logic       src_a, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem2reg, reg_wr;
  logic       pc_wr, branch, illegal, done;
  logic [1:0] src_b, alu_op, pc_src;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  multicycle_ctrl_fsm dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Op       (op),
    .i_MemReady (rdy),
    .o_AluSrcA  (src_a),
    .o_AluSrcB  (src_b),
    .o_AluOp    (alu_op),
    .o_IorD     (iord),
    .o_MemRead  (mem_rd),
    .o_MemWrite (mem_wr),
    .o_IRWrite  (ir_wr),
    .o_RegDst   (reg_dst),
    .o_MemtoReg (mem2reg),
    .o_RegWrite (reg_wr),
    .o_PCWrite  (pc_wr),
    .o_Branch   (branch),
    .o_PCSrc    (pc_src),
    .o_IllegalOp(illegal),
    .o_InstrDone(done),
    .o_State    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: state, SrcA, SrcB, AluOp, IorD, MemRead, MemWrite, IRWrite,
  // RegDst, MemtoReg, RegWrite, PCWrite, Branch, PCSrc, IllegalOp, InstrDone
  function automatic logic [21:0] pack(input logic [3:0] st, input logic sa, input logic [1:0] sb,
                                       input logic [1:0] ao, input logic io, input logic mr,
                                       input logic mw, input logic ir, input logic rd,
                                       input logic m2r, input logic rw, input logic pw,
                                       input logic br, input logic [1:0] ps, input logic il,
                                       input logic dn);
    return {st, sa, sb, ao, io, mr, mw, ir, rd, m2r, rw, pw, br, ps, il, dn};
  endfunction

  // Expected outputs for a state, written from the control table.
  function automatic logic [21:0] expect_vec(input logic [3:0] st, input logic [5:0] o,
                                             input logic r, input logic reset);
    logic known;
    known = (o == 6'h00) || (o == 6'h23) || (o == 6'h2B) || (o == 6'h04) ||
            (o == 6'h08) || (o == 6'h02);
    if (reset) return '0;
    case (st)
      4'd0:  return pack(st, 0, 2'b01, 2'b00, 0, 1, 0, r, 0, 0, 0, r, 0, 2'b00, 0, 0);
      4'd1:  return pack(st, 0, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, !known, 0);
      4'd2:  return pack(st, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      4'd3:  return pack(st, 0, 2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      4'd4:  return pack(st, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 1);
      4'd5:  return pack(st, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, r);
      4'd6:  return pack(st, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      4'd7:  return pack(st, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2'b00, 0, 1);
      4'd8:  return pack(st, 1, 2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 1);
      4'd9:  return pack(st, 1, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
      4'd10: return pack(st, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1);
      4'd11: return pack(st, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b10, 0, 1);
      default: return pack(st, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    endcase
  endfunction

  logic [21:0] sb_q[$];
  int          done_count;

  // One cycle: drive inputs after the edge, push the expected outputs, then
  // pop and compare at the falling edge.
  task automatic step(input string tag, input logic r, input logic [5:0] o, input logic m,
                      input logic [3:0] st);
    logic [21:0] exp_v, obs_v;
    @(posedge clk);
    #1;
    rst = r;
    op  = o;
    rdy = m;
    sb_q.push_back(expect_vec(st, o, m, r));
    @(negedge clk);
    exp_v = sb_q.pop_front();
    obs_v = pack(state, src_a, src_b, alu_op, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem2reg,
                 reg_wr, pc_wr, branch, pc_src, illegal, done);
    if (done) done_count++;
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
    checks++;
    assert ((mem_rd & mem_wr) === 1'b0) else begin
      failures++;
      $error("FAIL %s_rdwr_excl observed=%b%b expected=not both", tag, mem_rd, mem_wr);
    end
  endtask

  initial begin
    rst = 1'b1;
    op  = 6'h00;
    rdy = 1'b0;

    // Reset and entry into a store held in MEMWR, then reset mid-write.
    step("rst0",        1, 6'h2B, 1, 4'd0);
    step("t1_fetch",    0, 6'h2B, 1, 4'd0);
    step("t1_decode",   0, 6'h2B, 1, 4'd1);
    step("t1_memadr",   0, 6'h2B, 1, 4'd2);
    step("t1_memwr",    0, 6'h2B, 0, 4'd5);
    step("t1_rst_mw",   1, 6'h2B, 0, 4'd5);
    step("t1_rst_hold", 1, 6'h2B, 0, 4'd0);
    step("t1_fetchwait",0, 6'h2B, 0, 4'd0);
    checks++;
    assert (state === 4'd0 && mem_rd === 1'b1) else begin
      failures++;
      $error("FAIL t1_fetch_after_rst observed=%0d/%b expected=0/1", state, mem_rd);
    end

    // Load word, ready tied high.
    done_count = 0;
    step("t2_fetch",    0, 6'h23, 1, 4'd0);
    step("t2_decode",   0, 6'h23, 1, 4'd1);
    step("t2_memadr",   0, 6'h23, 1, 4'd2);
    step("t2_memrd",    0, 6'h23, 1, 4'd3);
    step("t2_memwb",    0, 6'h23, 1, 4'd4);
    checks++;
    assert (done_count === 1) else begin
      failures++;
      $error("FAIL t2_done_once observed=%0d expected=1", done_count);
    end

    // Load with a memory stall in FETCH and MEMRD.
    step("t2b_fwait",   0, 6'h23, 0, 4'd0);
    step("t2b_fetch",   0, 6'h23, 1, 4'd0);
    step("t2b_decode",  0, 6'h23, 1, 4'd1);
    step("t2b_memadr",  0, 6'h23, 1, 4'd2);
    step("t2b_rdwait",  0, 6'h23, 0, 4'd3);
    step("t2b_memrd",   0, 6'h23, 1, 4'd3);
    step("t2b_memwb",   0, 6'h23, 1, 4'd4);

    // R-type.
    step("t3_fetch",    0, 6'h00, 1, 4'd0);
    step("t3_decode",   0, 6'h00, 1, 4'd1);
    step("t3_execr",    0, 6'h00, 1, 4'd6);
    step("t3_aluwb",    0, 6'h00, 1, 4'd7);

    // Store with ready low for 3 cycles in MEMWR.
    step("t4_fetch",    0, 6'h2B, 1, 4'd0);
    step("t4_decode",   0, 6'h2B, 1, 4'd1);
    step("t4_memadr",   0, 6'h2B, 1, 4'd2);
    step("t4_wait1",    0, 6'h2B, 0, 4'd5);
    step("t4_wait2",    0, 6'h2B, 0, 4'd5);
    step("t4_wait3",    0, 6'h2B, 0, 4'd5);
    step("t4_memwr",    0, 6'h2B, 1, 4'd5);

    // Branch then jump.
    step("t5_fetch_b",  0, 6'h04, 1, 4'd0);
    step("t5_decode_b", 0, 6'h04, 1, 4'd1);
    step("t5_branch",   0, 6'h04, 1, 4'd8);
    step("t5_fetch_j",  0, 6'h02, 1, 4'd0);
    step("t5_decode_j", 0, 6'h02, 1, 4'd1);
    step("t5_jump",     0, 6'h02, 1, 4'd11);

    // Add immediate.
    step("addi_fetch",  0, 6'h08, 1, 4'd0);
    step("addi_decode", 0, 6'h08, 1, 4'd1);
    step("addi_execi",  0, 6'h08, 1, 4'd9);
    step("addi_iwb",    0, 6'h08, 1, 4'd10);

    // Illegal opcode.
    step("t6_fetch",    0, 6'h3F, 1, 4'd0);
    step("t6_decode",   0, 6'h3F, 1, 4'd1);
    step("t6_refetch",  0, 6'h00, 0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
